// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and encodings for the data-RAM arbiter between the CPU
// and the display burst reader.
package dmem_arbiter_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 8;
  localparam int MAX_WAIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } burst_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DISP = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_burst_gen.sv
// Display burst sequencer: latches base/len, walks the word addresses as the
// arbiter grants slots, and flags completion.
//
//   state | meaning
//   IDLE  | no burst; accepts disp_start
//   BURST | requesting a slot each cycle until len words are issued
//   DRAIN | last read in flight; disp_done asserted this cycle
module dmem_burst_gen #(
  parameter int ADDR_W = dmem_arbiter_pkg::ADDR_W,
  parameter int LEN_W  = dmem_arbiter_pkg::LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_start,
  input  logic [ADDR_W-1:0] disp_base,
  input  logic [LEN_W-1:0]  disp_len,
  input  logic              disp_win,
  output logic              disp_want,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              disp_busy,
  output logic              disp_done
);
  import dmem_arbiter_pkg::*;

  burst_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic              done_q, done_d;
  logic              last_word;

  assign last_word = (issued_q == len_q - LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (disp_start) begin
          if (disp_len != '0) begin
            state_d  = BURST;
            base_d   = disp_base;
            len_d    = disp_len;
            issued_d = '0;
          end else begin
            done_d = 1'b1;  // empty burst completes without touching the RAM
          end
        end
      end
      BURST: begin
        if (disp_win) begin
          issued_d = issued_q + LEN_W'(1);
          if (last_word) begin
            state_d = DRAIN;
            done_d  = 1'b1;
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

  assign disp_want = (state_q == BURST);
  assign disp_busy = (state_q != IDLE);
  assign disp_addr = base_q + ADDR_W'(issued_q);
  assign disp_done = done_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, the display burst is forced
// a slot after MAX_WAIT consecutive losses.
module dmem_arbiter #(
  parameter int ADDR_W   = dmem_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = dmem_arbiter_pkg::DATA_W,
  parameter int LEN_W    = dmem_arbiter_pkg::LEN_W,
  parameter int MAX_WAIT = dmem_arbiter_pkg::MAX_WAIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              disp_start,
  input  logic [ADDR_W-1:0] disp_base,
  input  logic [LEN_W-1:0]  disp_len,
  output logic              disp_busy,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_done,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);
  import dmem_arbiter_pkg::*;

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic              disp_want;
  logic              disp_win;
  logic              cpu_win;
  logic [ADDR_W-1:0] disp_addr;
  logic [WAIT_W-1:0] wait_q, wait_d;
  owner_e            owner_q, owner_d;

  dmem_burst_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_burst_gen (
    .clock     (clock),
    .reset     (reset),
    .disp_start(disp_start),
    .disp_base (disp_base),
    .disp_len  (disp_len),
    .disp_win  (disp_win),
    .disp_want (disp_want),
    .disp_addr (disp_addr),
    .disp_busy (disp_busy),
    .disp_done (disp_done)
  );

  assign disp_win  = disp_want & (~cpu_req | (wait_q == WAIT_W'(MAX_WAIT)));
  assign cpu_win   = cpu_req & ~disp_win;
  assign cpu_stall = cpu_req & disp_win;

  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (cpu_win) begin
      ram_wEn    = cpu_wEn;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_wdata;
    end else if (disp_win) begin
      ram_addr = disp_addr;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!disp_want || disp_win) begin
      wait_d = '0;
    end else if (cpu_win && (wait_q != WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    // Only reads leave data to return next cycle; CPU writes finish in-slot.
    owner_d = OWN_NONE;
    if (cpu_win && !cpu_wEn) begin
      owner_d = OWN_CPU;
    end else if (disp_win) begin
      owner_d = OWN_DISP;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q  <= '0;
      owner_q <= OWN_NONE;
    end else begin
      wait_q  <= wait_d;
      owner_q <= owner_d;
    end
  end

  assign cpu_rvalid  = (owner_q == OWN_CPU);
  assign disp_rvalid = (owner_q == OWN_DISP);
  assign cpu_rdata   = cpu_rvalid  ? ram_dataOut : '0;
  assign disp_rdata  = disp_rvalid ? ram_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM plus a slot-level reference model
// of the priority / forced-grant rules.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_wEn;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        disp_start;
  logic [11:0] disp_base;
  logic [7:0]  disp_len;
  logic        disp_busy, disp_rvalid, disp_done;
  logic [31:0] disp_rdata;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn, ram_dataOut;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:4095];

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wEn    (cpu_wEn),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .disp_start (disp_start),
    .disp_base  (disp_base),
    .disp_len   (disp_len),
    .disp_busy  (disp_busy),
    .disp_rdata (disp_rdata),
    .disp_rvalid(disp_rvalid),
    .disp_done  (disp_done),
    .ram_wEn    (ram_wEn),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM: read returns the pre-write contents.
  initial begin
    ram_dataOut = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    forever begin
      @(posedge clock);
      ram_dataOut <= mem[ram_addr];
      if (ram_wEn) mem[ram_addr] = ram_dataIn;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_wEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_start = 1'b0; disp_base = '0; disp_len = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    #2;
    vectors++;
    if ({cpu_stall, cpu_rvalid, cpu_rdata, disp_busy, disp_rdata, disp_rvalid,
         disp_done, ram_wEn, ram_addr, ram_dataIn} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b ram_addr=%h ram_wEn=%b expected all zero",
               disp_busy, disp_done, ram_addr, ram_wEn);
    end
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic test_cpu_write();
    cyc();
    cpu_req = 1'b1; cpu_wEn = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h12345678;
    #1;
    vectors++;
    if (ram_wEn !== 1'b1 || ram_addr !== 12'h020 || ram_dataIn !== 32'h12345678 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_write_drive: got wEn=%b addr=%h din=%h stall=%b expected 1/020/12345678/0",
               ram_wEn, ram_addr, ram_dataIn, cpu_stall);
    end
    cyc();
    cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if (cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_write_norvalid: got %b expected 0", cpu_rvalid);
    end
    cyc();
    drive_idle();
    #1;
    vectors++;
    if (cpu_rvalid !== 1'b0 || mem[12'h020] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL cpu_write_mem: got rvalid=%b mem=%h expected 0/12345678", cpu_rvalid, mem[12'h020]);
    end
  endtask

  task automatic test_cpu_read();
    cyc();
    cpu_req = 1'b1; cpu_wEn = 1'b0; cpu_addr = 12'h010; cpu_wdata = '0;
    #1;
    vectors++;
    if (ram_addr !== 12'h010 || ram_wEn !== 1'b0 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_read_addr: got addr=%h wEn=%b stall=%b expected 010/0/0", ram_addr, ram_wEn, cpu_stall);
    end
    cyc();
    drive_idle();
    #1;
    vectors++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || disp_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_read_data: got rvalid=%b data=%h expected 1/deadbeef", cpu_rvalid, cpu_rdata);
    end
  endtask

  // mode 0: CPU idle, 1: CPU reads every cycle, 2: random CPU traffic with
  // disp_start held high throughout the burst.
  task automatic run_burst(input logic [11:0] base, input int len, input int mode,
                           output int stalls, output int cycles);
    int          issued = 0;
    int          lost = 0;
    bit          in_burst, dwin, cwin;
    bit          hold = 0;
    bit          exp_dv = 0, exp_cv = 0;
    logic [31:0] exp_dd = '0, exp_cd = '0;
    logic [11:0] exp_addr;
    stalls = 0;
    cycles = 0;
    cyc();
    drive_idle();
    disp_start = 1'b1; disp_base = base; disp_len = 8'(len);
    #1;
    vectors++;
    if (disp_busy !== 1'b0 || disp_done !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_start_idle: got busy=%b done=%b expected 0/0", disp_busy, disp_done);
    end
    for (int c = 0; c < len * (MAX_WAIT + 1) + 2; c++) begin
      cyc();
      disp_start = (mode == 2);
      disp_base  = 12'($urandom);
      disp_len   = 8'($urandom_range(0, 255));
      if (!hold) begin
        case (mode)
          0: cpu_req = 1'b0;
          1: begin cpu_req = 1'b1; cpu_wEn = 1'b0; cpu_addr = 12'h040; cpu_wdata = '0; end
          default: begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_wEn   = 1'($urandom_range(0, 1));
            cpu_addr  = base + 12'($urandom_range(0, 7));
            cpu_wdata = $urandom;
          end
        endcase
      end
      #1;
      in_burst = (issued < len);
      dwin     = in_burst && (!cpu_req || lost == MAX_WAIT);
      cwin     = cpu_req && !dwin;
      exp_addr = dwin ? 12'(base + issued) : (cwin ? cpu_addr : 12'h000);
      vectors++;
      if (cpu_stall !== (cpu_req && dwin)) begin
        miscompares++;
        $display("FAIL burst_stall c%0d: got %b expected %b", c, cpu_stall, cpu_req && dwin);
      end
      vectors++;
      if (ram_addr !== exp_addr || ram_wEn !== (cwin && cpu_wEn)) begin
        miscompares++;
        $display("FAIL burst_ram_addr c%0d: got %h/%b expected %h/%b", c, ram_addr, ram_wEn, exp_addr, cwin && cpu_wEn);
      end
      vectors++;
      if (ram_dataIn !== (cwin ? cpu_wdata : 32'h0)) begin
        miscompares++;
        $display("FAIL burst_ram_din c%0d: got %h expected %h", c, ram_dataIn, cwin ? cpu_wdata : 32'h0);
      end
      vectors++;
      if (disp_rvalid !== exp_dv || disp_rdata !== (exp_dv ? exp_dd : 32'h0)) begin
        miscompares++;
        $display("FAIL burst_disp_data c%0d: got %b/%h expected %b/%h", c, disp_rvalid, disp_rdata, exp_dv, exp_dd);
      end
      vectors++;
      if (cpu_rvalid !== exp_cv || cpu_rdata !== (exp_cv ? exp_cd : 32'h0)) begin
        miscompares++;
        $display("FAIL burst_cpu_data c%0d: got %b/%h expected %b/%h", c, cpu_rvalid, cpu_rdata, exp_cv, exp_cd);
      end
      vectors++;
      if (disp_busy !== 1'b1 || disp_done !== !in_burst) begin
        miscompares++;
        $display("FAIL burst_busy_done c%0d: got %b/%b expected 1/%b", c, disp_busy, disp_done, !in_burst);
      end
      exp_dv = dwin;
      exp_dd = mem[exp_addr];
      exp_cv = cwin && !cpu_wEn;
      exp_cd = mem[cpu_addr];
      hold   = cpu_req && dwin;
      if (hold) stalls++;
      cycles++;
      if (dwin) begin
        issued++;
        lost = 0;
      end else if (in_burst && cwin && lost < MAX_WAIT) begin
        lost++;
      end
      if (!in_burst) break;
    end
    cyc();
    drive_idle();
    #1;
    vectors++;
    if (disp_busy !== 1'b0 || disp_done !== 1'b0 || disp_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_end: got busy=%b done=%b rvalid=%b expected 0/0/0", disp_busy, disp_done, disp_rvalid);
    end
    vectors++;
    if (cpu_rvalid !== exp_cv || cpu_rdata !== (exp_cv ? exp_cd : 32'h0)) begin
      miscompares++;
      $display("FAIL burst_end_cpu: got %b/%h expected %b/%h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd);
    end
  endtask

  task automatic test_wrap_burst();
    int s, c;
    run_burst(12'hFFE, 4, 0, s, c);
    vectors++;
    if (c !== 5 || s !== 0) begin
      miscompares++;
      $display("FAIL wrap_busy_cycles: got %0d cycles %0d stalls expected 5/0", c, s);
    end
  endtask

  task automatic test_contention();
    int s, c;
    run_burst(12'h200, 2, 1, s, c);
    vectors++;
    if (c !== 11 || s !== 2) begin
      miscompares++;
      $display("FAIL contention_pattern: got %0d cycles %0d stalls expected 11/2", c, s);
    end
  endtask

  task automatic test_start_ignored();
    int s, c;
    run_burst(12'h300, 3, 2, s, c);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      vectors++;
      if (disp_busy !== 1'b0 || disp_done !== 1'b0) begin
        miscompares++;
        $display("FAIL start_ignored_idle: got busy=%b done=%b expected 0/0", disp_busy, disp_done);
      end
    end
  endtask

  task automatic test_zero_len();
    cyc();
    drive_idle();
    disp_start = 1'b1; disp_base = 12'h123; disp_len = 8'd0;
    #1;
    vectors++;
    if (ram_wEn !== 1'b0 || ram_addr !== 12'h000 || disp_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_ram: got wEn=%b addr=%h busy=%b expected 0/000/0", ram_wEn, ram_addr, disp_busy);
    end
    cyc();
    disp_start = 1'b0;
    #1;
    vectors++;
    if (disp_done !== 1'b1 || disp_busy !== 1'b0 || ram_addr !== 12'h000 || disp_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_done: got done=%b busy=%b addr=%h expected 1/0/000", disp_done, disp_busy, ram_addr);
    end
    cyc();
    #1;
    vectors++;
    if (disp_done !== 1'b0 || disp_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_after: got done=%b busy=%b expected 0/0", disp_done, disp_busy);
    end
  endtask

  task automatic test_random();
    int s, c;
    for (int n = 0; n < 20; n++) begin
      run_burst(12'($urandom), $urandom_range(1, 12), $urandom_range(0, 2), s, c);
    end
  endtask

  task automatic test_reset_mid_burst();
    cyc();
    drive_idle();
    disp_start = 1'b1; disp_base = 12'h100; disp_len = 8'd5;
    cyc();
    disp_start = 1'b0;
    cyc();
    cyc();
    #1;
    vectors++;
    if (ram_addr !== 12'h102 || disp_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: got addr=%h busy=%b expected 102/1", ram_addr, disp_busy);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({cpu_stall, cpu_rvalid, cpu_rdata, disp_busy, disp_rdata, disp_rvalid,
         disp_done, ram_wEn, ram_addr, ram_dataIn} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got busy=%b rvalid=%b addr=%h expected all zero",
               disp_busy, disp_rvalid, ram_addr);
    end
    repeat (2) cyc();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      #1;
      vectors++;
      if (disp_busy !== 1'b0 || disp_done !== 1'b0 || ram_addr !== 12'h000) begin
        miscompares++;
        $display("FAIL midreset_after c%0d: got busy=%b done=%b addr=%h expected 0/0/000",
                 i, disp_busy, disp_done, ram_addr);
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_wrap_burst();
    test_contention();
    test_zero_len();
    test_start_ignored();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (12-bit address, 32-bit data, synchronous read with data valid one cycle after address) between two requesters: the processor's memory port and a display burst reader that fetches sprite and frame words for the screen logic.
- The CPU has priority. A starvation counter guarantees the display burst forward progress.
- Sits between processor, RAM and the display path inside the top-level wrapper.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 32, RAM data width.
- LEN_W, 8, burst length field width (up to 255 words).
- MAX_WAIT, 4, consecutive lost slots after which the display is forced a grant.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU accesses RAM this cycle
- cpu_wEn  in  1  CPU access is a write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU access not granted this cycle; hold request
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid
- disp_start  in  1  start burst (accepted only in IDLE)
- disp_base  in  ADDR_W  burst start address
- disp_len  in  LEN_W  words in burst
- disp_busy  out  1  burst in progress
- disp_rdata  out  DATA_W  burst read data
- disp_rvalid  out  1  disp_rdata valid
- disp_done  out  1  one-cycle pulse, burst complete
- ram_wEn  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_dataIn  out  DATA_W  RAM write data
- ram_dataOut  in  DATA_W  RAM read data (one cycle after address)

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; counters, owner tag and latched base/len clear to 0.
  - All outputs are 0; ram_* are 0 because no owner is granted.
  - Reset mid-burst abandons the burst and no disp_done is issued.
- FSM states and transitions:
  - IDLE -> BURST when disp_start=1 and disp_len!=0; latch base and len, issued=0.
  - IDLE with disp_start=1 and disp_len=0: stay in IDLE, disp_done pulses on the next cycle, no RAM access.
  - BURST -> DRAIN on the edge after the display wins its slot with issued=len-1.
  - DRAIN -> IDLE after one cycle.
  - disp_start is ignored in BURST and DRAIN.
  - disp_busy=1 in BURST and DRAIN.
- Slot arbitration (combinational, every cycle):
  - disp_want = (state==BURST).
  - The display wins if disp_want and (!cpu_req or wait_cnt==MAX_WAIT).
  - Otherwise the CPU wins if cpu_req.
  - cpu_stall = cpu_req & display wins.
- wait_cnt:
  - Increments when disp_want and the CPU wins.
  - Clears when the display wins or when leaving BURST.
  - Saturates at MAX_WAIT.
- RAM drive (combinational from the winner):
  - CPU wins: ram_addr=cpu_addr, ram_wEn=cpu_wEn, ram_dataIn=cpu_wdata.
  - Display wins: ram_addr=(base+issued) mod 2^ADDR_W (wraps), ram_wEn=0.
  - No winner: all ram_* are 0.
  - The display never writes.
- Read return:
  - A registered owner tag (NONE/CPU/DISP) records which requester won a read in cycle N.
  - In cycle N+1 the owner's rvalid=1 and its rdata=ram_dataOut; the non-owner's rdata is 0.
  - CPU writes complete in the granted cycle and produce no rvalid.
- issued increments on each display win.
- disp_done=1 in the DRAIN cycle, coincident with the last disp_rvalid.
- CPU contract: while cpu_stall=1 the CPU holds cpu_req, cpu_wEn, cpu_addr and cpu_wdata stable. Worst-case CPU stall is 1 cycle per MAX_WAIT+1 contested cycles.
- Latency:
  - Uncontended burst of L words: disp_busy for L+1 cycles, disp_done L cycles after the start edge.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W constants.
  - FSM state encoding: IDLE, BURST, DRAIN.
  - Owner tag encoding: OWN_NONE, OWN_CPU, OWN_DISP.
- One natural sub-module, dmem_burst_gen, contains:
  - The FSM.
  - The base, len and issued registers.
  - Address generation.
  - disp_done generation.
- It exposes disp_want and disp_addr and takes a disp_win input.
- The top level holds the arbitration, wait_cnt, owner tag and data return muxing.

Test Plan:
- Reset=0 asserted mid-burst (issued=2 of 5):
  - All outputs go to 0 immediately.
  - After release the block is in IDLE, disp_busy=0, and no disp_done ever pulses.
- CPU read only:
  - Stimulus: cpu_req=1, cpu_wEn=0, cpu_addr=0x010, RAM[0x010]=0xDEADBEEF.
  - Response: ram_addr=0x010 the same cycle; next cycle cpu_rvalid=1 with cpu_rdata=0xDEADBEEF; cpu_stall stays 0.
- Uncontended wrapping burst:
  - Stimulus: disp_start, disp_base=0xFFE, disp_len=4.
  - Response: ram_addr is 0xFFE, 0xFFF, 0x000, 0x001 on consecutive cycles; 4 disp_rvalid with the matching data; disp_done with the 4th; disp_busy for 5 cycles.
- Contention:
  - Stimulus: cpu_req held 1 continuously, burst disp_len=2, MAX_WAIT=4.
  - Response: CPU wins 4 cycles; the display wins the 5th with cpu_stall=1 for exactly that cycle; the pattern repeats; disp_done follows the 10th cycle's read.
- Zero-length burst:
  - Stimulus: disp_start with disp_len=0.
  - Response: disp_done=1 the next cycle; disp_busy never 1; ram_wEn and ram_addr stay 0.
- Start ignored while busy, and write during burst:
  - A second disp_start during BURST is ignored; exactly one disp_done results.
  - A CPU write to 0x020 of 0x12345678 while the display is idle-eligible gives ram_wEn=1 the same cycle and no cpu_rvalid.
